mem_lat_model: RTL and testbench

- Behavioural-plus-synthesizable word memory that serves a processor instruction or data port over val/rdy, using mem_req_4B_t / mem_resp_4B_t.
- Sits directly downstream of the processor's imemreq/dmemreq ports and produces imemresp/dmemresp.
- Adds a configurable fixed access latency and a bounded in-order response queue, so the bench can exercise processor stalls on memory latency and backpressure.

---
 rtl/mem_lat_model_if.sv | 43 ++++
 rtl/mem_lat_model.sv | 148 ++++++++++++++
 tb/tb_mem_lat_model.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_lat_model_if.sv
// Memory port message types and the val/rdy request/response bundle
// shared by the latency memory and whoever drives it.
package mem_lat_model_pkg;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [31:0] addr;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_req_4B_t;

  typedef struct packed {
    logic [2:0]  type_;
    logic [7:0]  opaque;
    logic [1:0]  test;
    logic [1:0]  len;
    logic [31:0] data;
  } mem_resp_4B_t;

endpackage

interface mem_lat_model_if;
  import mem_lat_model_pkg::*;

  mem_req_4B_t  req_msg;
  logic         req_val;
  logic         req_rdy;
  mem_resp_4B_t resp_msg;
  logic         resp_val;
  logic         resp_rdy;

  modport master (
    output req_msg, req_val, resp_rdy,
    input  req_rdy, resp_msg, resp_val
  );

  modport slave (
    input  req_msg, req_val, resp_rdy,
    output req_rdy, resp_msg, resp_val
  );

endinterface

// File: rtl/mem_lat_model.sv
// Word memory with fixed access latency and a bounded in-order
// response queue, serving one processor port over val/rdy.
module mem_lat_model
  import mem_lat_model_pkg::*;
#(
  parameter int NUM_WORDS = 1024,
  parameter int LAT       = 2,
  parameter int QDEPTH    = 4
) (
  input logic            clk,
  input logic            rst,
  mem_lat_model_if.slave bus
);

  localparam int AW = $clog2(NUM_WORDS);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;

  logic [31:0]  mem_q [NUM_WORDS];
  mem_resp_4B_t fifo_q [QDEPTH];

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] fcnt_q;
  logic [PW-1:0] wr_q;
  logic [PW-1:0] rd_q;

  logic          acc;
  logic          xfer;
  logic          push;
  mem_resp_4B_t  push_msg;
  mem_resp_4B_t  in_msg;

  logic [AW-1:0] idx;
  logic [4:0]    off_b;
  logic [2:0]    nb;
  logic [31:0]   lmask;
  logic [31:0]   word;
  logic [31:0]   rdata;
  logic [31:0]   wmask;
  logic [31:0]   wdata;
  logic          is_rd;
  logic          is_wr;
  logic          unused_addr;

  function automatic logic [PW-1:0] nxt(
    input logic [PW-1:0] p
  );
    return (p == PW'(QDEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // rst gates ready so nothing is accepted while reset is held
  assign bus.req_rdy  = !rst && (cnt_q < CW'(QDEPTH));
  assign bus.resp_val = (fcnt_q != '0);
  assign bus.resp_msg = fifo_q[rd_q];

  assign acc  = bus.req_val && bus.req_rdy;
  assign xfer = bus.resp_val && bus.resp_rdy;

  assign unused_addr = ^bus.req_msg.addr[31:AW+2];

  always_comb begin
    idx    = bus.req_msg.addr[AW+1:2];
    off_b  = {bus.req_msg.addr[1:0], 3'b000};
    nb     = (bus.req_msg.len == 2'd0) ? 3'd4
                                       : {1'b0, bus.req_msg.len};
    lmask  = ~(32'hffff_ffff << {nb, 3'b000});
    word   = mem_q[idx];
    rdata  = (word >> off_b) & lmask;
    // lanes shifted past bit 31 fall off, dropping bytes beyond the word
    wmask  = lmask << off_b;
    wdata  = (bus.req_msg.data & lmask) << off_b;
    is_rd  = (bus.req_msg.type_ == 3'd0);
    is_wr  = (bus.req_msg.type_ == 3'd1)
          || (bus.req_msg.type_ == 3'd2);
    in_msg = '{
      type_:  bus.req_msg.type_,
      opaque: bus.req_msg.opaque,
      test:   2'd0,
      len:    bus.req_msg.len,
      data:   is_rd ? rdata : 32'd0
    };
  end

  always_ff @(posedge clk) begin
    if (acc && is_wr)
      mem_q[idx] <= (word & ~wmask) | wdata;
  end

  generate
    if (LAT == 1) begin : g_direct
      assign push     = acc;
      assign push_msg = in_msg;
    end else begin : g_pipe
      logic         pv_q [LAT-1];
      mem_resp_4B_t pm_q [LAT-1];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          for (int i = 0; i < LAT - 1; i++) begin
            pv_q[i] <= 1'b0;
            pm_q[i] <= '0;
          end
        end else begin
          pv_q[0] <= acc;
          pm_q[0] <= in_msg;
          for (int i = 1; i < LAT - 1; i++) begin
            pv_q[i] <= pv_q[i-1];
            pm_q[i] <= pm_q[i-1];
          end
        end
      end

      assign push     = pv_q[LAT-2];
      assign push_msg = pm_q[LAT-2];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (push)
      fifo_q[wr_q] <= push_msg;
  end

  // outstanding count caps the pipe plus queue, so the FIFO never overflows
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q   <= '0;
      rd_q   <= '0;
      fcnt_q <= '0;
      cnt_q  <= '0;
    end else begin
      if (push)
        wr_q <= nxt(wr_q);
      if (xfer)
        rd_q <= nxt(rd_q);
      unique case ({push, xfer})
        2'b10:   fcnt_q <= fcnt_q + CW'(1);
        2'b01:   fcnt_q <= fcnt_q - CW'(1);
        default: fcnt_q <= fcnt_q;
      endcase
      unique case ({acc, xfer})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lat_model.sv
// Bench for mem_lat_model: directed and random traffic against a
// byte-array memory and a due-time response queue.
module tb_mem_lat_model;
  import mem_lat_model_pkg::*;

  localparam int NW  = 1024;
  localparam int LAT = 2;
  localparam int QD  = 4;
  localparam int NB  = NW * 4;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  mem_lat_model_if bus();

  mem_lat_model #(
    .NUM_WORDS(NW),
    .LAT(LAT),
    .QDEPTH(QD)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    mem_resp_4B_t msg;
    int           due;
  } exp_t;

  exp_t         q[$];
  logic [7:0]   ref_mem [NB];
  int           passed = 0;
  int           failed = 0;
  int           total = 0;
  int           cyc_n = 0;
  int           n_acc = 0;
  logic         last_acc = 1'b0;
  logic         last_xfer = 1'b0;
  mem_resp_4B_t last_resp;
  int           opq[$];
  int           xcyc[$];

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Byte-level reference: addresses wrap modulo the memory size.
  function automatic mem_resp_4B_t model_access(input mem_req_4B_t r);
    mem_resp_4B_t rs;
    int unsigned  a;
    int unsigned  base;
    int unsigned  off;
    int unsigned  n;
    a    = r.addr % NB;
    off  = a % 4;
    base = a - off;
    n    = (r.len == 2'd0) ? 4 : r.len;
    rs   = '0;
    rs.type_  = r.type_;
    rs.opaque = r.opaque;
    rs.len    = r.len;
    for (int i = 0; i < 4; i++) begin
      if (i < n && off + i < 4) begin
        if (r.type_ == 3'd0)
          rs.data[8*i +: 8] = ref_mem[base + off + i];
        else if (r.type_ == 3'd1 || r.type_ == 3'd2)
          ref_mem[base + off + i] = r.data[8*i +: 8];
      end
    end
    return rs;
  endfunction

  task automatic tick();
    logic ev;
    logic acc;
    #3;
    ev = (q.size() > 0) && (q[0].due <= cyc_n);
    chk("req_rdy", bus.req_rdy, q.size() < QD);
    chk("resp_val", bus.resp_val, ev);
    if (ev)
      chk("resp_msg", bus.resp_msg, q[0].msg);
    acc       = bus.req_val && (q.size() < QD);
    last_xfer = ev && bus.resp_rdy;
    if (last_xfer) begin
      last_resp = bus.resp_msg;
      opq.push_back(int'(bus.resp_msg.opaque));
      xcyc.push_back(cyc_n);
      void'(q.pop_front());
    end
    last_acc = acc;
    if (acc) begin
      q.push_back('{model_access(bus.req_msg), cyc_n + LAT});
      n_acc++;
    end
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic set_req(input int t, input logic [31:0] a,
                         input int l, input logic [31:0] d,
                         input int o);
    bus.req_msg.type_  = 3'(t);
    bus.req_msg.addr   = a;
    bus.req_msg.len    = 2'(l);
    bus.req_msg.data   = d;
    bus.req_msg.opaque = 8'(o);
    bus.req_val        = 1'b1;
  endtask

  task automatic send(input int t, input logic [31:0] a,
                      input int l, input logic [31:0] d,
                      input int o);
    int k;
    k = 0;
    set_req(t, a, l, d, o);
    do begin
      tick();
      k++;
    end while (!last_acc && k < 50);
    chk("send_acc", last_acc, 1'b1);
    bus.req_val = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    bus.req_val  = 1'b0;
    bus.resp_rdy = 1'b1;
    while (q.size() > 0 && k < 100) begin
      tick();
      k++;
    end
    chk("drain_empty", q.size(), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int a_cyc;
    int acc0;
    logic [31:0] v;

    bus.req_msg  = '0;
    bus.req_val  = 1'b0;
    bus.resp_rdy = 1'b1;

    // reset held
    @(posedge clk);
    #1;
    chk("rst_resp_val", bus.resp_val, 1'b0);
    chk("rst_req_rdy", bus.req_rdy, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // unloaded latency
    send(1, 32'h10, 0, 32'hDEADBEEF, 8'h5A);
    a_cyc = cyc_n - 1;
    drain();
    chk("wr_lat", xcyc[$] - a_cyc, LAT);
    chk("wr_type", last_resp.type_, 3'd1);
    chk("wr_data", last_resp.data, 32'd0);
    chk("wr_opq", last_resp.opaque, 8'h5A);
    send(0, 32'h10, 0, 32'h0, 8'hA5);
    a_cyc = cyc_n - 1;
    drain();
    chk("rd_lat", xcyc[$] - a_cyc, LAT);
    chk("rd_data", last_resp.data, 32'hDEADBEEF);
    chk("rd_opq", last_resp.opaque, 8'hA5);

    // fill the random-traffic region (words 0..15), sparing 0x10
    for (int w = 0; w < 16; w++)
      if (w != 4)
        send(1, 32'(w * 4), 0, $urandom, w);
    drain();

    // subword access
    send(1, 32'h20, 0, 32'h11223344, 1);
    send(1, 32'h21, 1, 32'hFFFFFFAA, 2);
    send(0, 32'h20, 0, 32'h0, 3);
    drain();
    chk("sub_word", last_resp.data, 32'h1122AA44);
    send(0, 32'h22, 2, 32'h0, 4);
    drain();
    chk("sub_half", last_resp.data, 32'h00001122);
    send(0, 32'h23, 3, 32'h0, 5);
    drain();
    chk("sub_tail", last_resp.data, 32'h00000011);

    // backpressure to full
    bus.resp_rdy = 1'b0;
    opq.delete();
    acc0 = n_acc;
    for (int i = 0; i < 8; i++) begin
      set_req(0, 32'(4 * (n_acc - acc0)), 0, 32'h0,
              8'h40 + (n_acc - acc0));
      tick();
    end
    bus.req_val = 1'b0;
    chk("bp_accepts", n_acc - acc0, 4);
    chk("bp_rdy_low", bus.req_rdy, 1'b0);
    bus.resp_rdy = 1'b1;
    tick();
    chk("bp_first_xfer", last_xfer, 1'b1);
    chk("bp_rerdy", bus.req_rdy, 1'b1);
    drain();
    chk("bp_count", opq.size(), 4);
    for (int i = 0; i < 4; i++)
      chk("bp_order", opq[i], 8'h40 + i);

    // streaming
    opq.delete();
    xcyc.delete();
    for (int i = 0; i < 16; i++) begin
      set_req(0, 32'(4 * i), 0, 32'h0, i);
      tick();
      chk("stream_acc", last_acc, 1'b1);
    end
    drain();
    chk("stream_count", xcyc.size(), 16);
    chk("stream_span", xcyc[15] - xcyc[0], 15);
    for (int i = 0; i < 16; i++)
      chk("stream_order", opq[i], i);

    // accept and transfer together at QDEPTH-1 outstanding
    bus.resp_rdy = 1'b0;
    for (int i = 0; i < QD - 1; i++)
      send(0, 32'(4 * i), 0, 32'h0, 8'h60 + i);
    for (int i = 0; i < LAT; i++)
      tick();
    set_req(0, 32'h8, 0, 32'h0, 8'h6F);
    bus.resp_rdy = 1'b1;
    tick();
    chk("sim_acc", last_acc, 1'b1);
    chk("sim_xfer", last_xfer, 1'b1);
    chk("sim_rdy", bus.req_rdy, 1'b1);
    chk("sim_outst", q.size(), QD - 1);
    drain();

    // reset mid-flight
    bus.resp_rdy = 1'b0;
    for (int i = 0; i < 3; i++)
      send(0, 32'(4 * i), 0, 32'h0, 8'h70 + i);
    tick();
    rst = 1'b1;
    #1;
    chk("mid_rst_val", bus.resp_val, 1'b0);
    chk("mid_rst_rdy", bus.req_rdy, 1'b0);
    q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.resp_rdy = 1'b1;
    for (int i = 0; i < 6; i++)
      tick();
    send(0, 32'h10, 0, 32'h0, 8'h7F);
    drain();
    chk("rst_keep", last_resp.data, 32'hDEADBEEF);

    // address wrap
    v = $urandom;
    send(1, 32'h1000, 0, v, 8'h80);
    send(0, 32'h0000, 0, 32'h0, 8'h81);
    drain();
    chk("wrap", last_resp.data, v);

    // random traffic
    for (int i = 0; i < 300; i++) begin
      bus.req_val = ($urandom_range(0, 3) != 0);
      bus.req_msg.type_  = 3'($urandom_range(0, 3));
      bus.req_msg.addr   = ($urandom & 32'hFFFF_F000)
                         | 32'($urandom_range(0, 63));
      bus.req_msg.len    = 2'($urandom_range(0, 3));
      bus.req_msg.data   = $urandom;
      bus.req_msg.opaque = 8'($urandom);
      bus.resp_rdy = ($urandom_range(0, 2) != 0);
      tick();
    end
    drain();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
